// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one word read at a time and offers the result to the decoder.
// Defining FETCH_TIMEOUT_EN adds a watchdog on unacknowledged memory requests.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_out,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StFault} state_e;

    state_e      state;
    logic [31:0] pc;
    logic        kill;
    logic        redir_bad;
    logic        timeout_hit;
    logic        go_fault;
    logic [31:0] req_next_pc;
    logic [31:0] hold_next_pc;

    always_comb begin
        redir_bad    = redirect && (redirect_pc[1:0] != 2'b00);
        go_fault     = (state != StFault) && (redir_bad || timeout_hit);
        req_next_pc  = redirect ? redirect_pc : pc;
        hold_next_pc = redirect ? redirect_pc : pc + 32'd4;
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] wait_cnt;

    // Zero outside REQ, so every new request (including a re-issue after a killed ack) starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != StReq || mem_ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 10'd1;
        end
    end

    assign timeout_hit = (state == StReq) && !mem_ack && (wait_cnt == TimeoutLast);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            fetch_fault <= 1'b0;
        end else if (go_fault) begin
            state       <= StFault;
            fetch_fault <= 1'b1;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            kill        <= 1'b0;
            if (redir_bad) begin
                pc <= redirect_pc;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (en) begin
                        state    <= StReq;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        if (redirect || kill) begin
                            // Stale data: drop it and re-issue at the current target.
                            kill     <= 1'b0;
                            pc       <= req_next_pc;
                            mem_addr <= req_next_pc;
                        end else begin
                            state       <= StHold;
                            mem_req     <= 1'b0;
                            instr       <= mem_rdata;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                        end
                    end else if (redirect) begin
                        pc   <= redirect_pc;
                        kill <= 1'b1;
                    end
                end
                StHold: begin
                    if (redirect || instr_ready) begin
                        pc          <= hold_next_pc;
                        instr_valid <= 1'b0;
                        if (en) begin
                            state    <= StReq;
                            mem_req  <= 1'b1;
                            mem_addr <= hold_next_pc;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                StFault: begin
                    state <= StFault;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responder, transaction-level model and per-cycle checker.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;    // ack in cycle 'lat' of a request; 0 = never ack

    // Model state
    logic [31:0] exp_pc;
    logic        mfault;
    int          wcnt;
    logic        prev_req, prev_ack, prev_valid, prev_hs, prev_redir;
    logic [31:0] prev_instr, prev_pcout, req_addr;
    logic [31:0] reqs[$];
    logic [31:0] consumed[$];
    int          cons_cyc[$];

    instr_fetch #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_out     (pc_out),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Memory responder: fixed latency per request, restarts counting after every ack.
    initial begin
        int  rcnt;
        logic was_ack;
        rcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            was_ack = mem_ack;
            if (!rst_n || !mem_req) begin
                mem_ack = 1'b0;
                rcnt    = 0;
            end else begin
                if (was_ack) rcnt = 0;
                mem_ack = (lat != 0) && (rcnt == lat - 1);
                rcnt++;
            end
            mem_rdata = memfn(mem_addr);
        end
    end

    // Per-cycle checker against the transaction-level model.
    always @(negedge clk) begin
        logic hs;
        if (!rst_n) begin
            check("rst mem_req", mem_req, 0);
            check("rst mem_addr", mem_addr, 32'h0);
            check("rst instr_valid", instr_valid, 0);
            check("rst instr", instr, 32'h0);
            check("rst pc_out", pc_out, 32'h0);
            check("rst fetch_fault", fetch_fault, 0);
            exp_pc = 32'h0;
            mfault = 1'b0;
            wcnt   = 0;
            prev_req = 0; prev_ack = 0; prev_valid = 0; prev_hs = 0; prev_redir = 0;
            reqs.delete();
            consumed.delete();
            cons_cyc.delete();
        end else begin
            check("req/valid exclusive", mem_req & instr_valid, 0);
            if (mfault) begin
                check("fault flag", fetch_fault, 1);
                check("fault mem_req", mem_req, 0);
                check("fault instr_valid", instr_valid, 0);
            end else begin
                check("no fault", fetch_fault, 0);
                if (mem_req) begin
                    if (!prev_req || prev_ack) begin
                        check("request addr", mem_addr, exp_pc);
                        reqs.push_back(mem_addr);
                        req_addr = mem_addr;
                    end else begin
                        check("addr stable", mem_addr, req_addr);
                    end
                end
                if (prev_valid && !prev_hs && !prev_redir) begin
                    check("hold valid", instr_valid, 1);
                    check("hold instr", instr, prev_instr);
                    check("hold pc_out", pc_out, prev_pcout);
                end else if (prev_valid) begin
                    check("valid drops", instr_valid, 0);
                end
                if (instr_valid) begin
                    check("present pc", pc_out, exp_pc);
                    check("present instr", instr, memfn(pc_out));
                end
            end
            hs = instr_valid && instr_ready;
            if (!mfault) begin
                if (hs) begin
                    consumed.push_back(pc_out);
                    cons_cyc.push_back(cyc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (redirect) begin
                    exp_pc = redirect_pc;
                    if (redirect_pc[1:0] != 2'b00) mfault = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                if (mem_req && !mem_ack) begin
                    wcnt++;
                    if (wcnt == 4) mfault = 1'b1;
                end else begin
                    wcnt = 0;
                end
`endif
            end
            prev_req   = mem_req;
            prev_ack   = mem_ack;
            prev_valid = instr_valid;
            prev_hs    = hs;
            prev_redir = redirect;
            prev_instr = instr;
            prev_pcout = pc_out;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_req && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " mem_req seen"}, mem_req, 1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " instr_valid seen"}, instr_valid, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        en          = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;

        // 1: zero-wait memory, always ready
        lat = 1; en = 1'b1; instr_ready = 1'b1;
        do_reset();
        n = 0;
        while (consumed.size() < 3 && n < 40) begin
            step();
            n++;
        end
        check("t1 consumed count", consumed.size() >= 3, 1);
        if (consumed.size() >= 3 && reqs.size() >= 3) begin
            check("t1 req0", reqs[0], 32'h0);
            check("t1 req1", reqs[1], 32'h4);
            check("t1 req2", reqs[2], 32'h8);
            check("t1 pc1", consumed[1], 32'h4);
            check("t1 pc2", consumed[2], 32'h8);
            check("t1 spacing a", cons_cyc[1] - cons_cyc[0], 2);
            check("t1 spacing b", cons_cyc[2] - cons_cyc[1], 2);
        end

        // 2: 3-cycle latency, decoder stalls 4 cycles
        lat = 3; instr_ready = 1'b0;
        do_reset();
        wait_valid("t2");
        repeat (4) step();
        check("t2 held valid", instr_valid, 1);
        check("t2 held mem_req", mem_req, 0);
        check("t2 held pc", pc_out, 32'h0);
        check("t2 held instr", instr, 32'hDEAD_0000);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("t2 next req", mem_req, 1);
        check("t2 next addr", mem_addr, 32'h4);

        // 3: redirect in first cycle of a 3-cycle access
        lat = 3; instr_ready = 1'b1;
        do_reset();
        wait_req("t3");
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        wait_valid("t3");
        check("t3 first presented pc", pc_out, 32'h100);
        check("t3 req count", reqs.size(), 2);
        if (reqs.size() >= 2) check("t3 req1", reqs[1], 32'h100);

        // 4: redirect together with the handshake
        lat = 1; instr_ready = 1'b0;
        do_reset();
        wait_valid("t4");
        redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
        step();
        redirect = 1'b0; instr_ready = 1'b0;
        check("t4 req", mem_req, 1);
        check("t4 addr", mem_addr, 32'h200);
        check("t4 consumed once", consumed.size(), 1);
        wait_valid("t4b");
        check("t4 pc", pc_out, 32'h200);

        // 5: misaligned redirect faults; only reset clears it
        lat = 3; instr_ready = 1'b1;
        do_reset();
        wait_req("t5");
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        check("t5 fault", fetch_fault, 1);
        check("t5 mem_req", mem_req, 0);
        step();
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        repeat (3) step();
        check("t5 still fault", fetch_fault, 1);
        check("t5 still idle", mem_req, 0);
        rst_n = 1'b0;
        #1;
        check("t5 async clear", fetch_fault, 0);
        do_reset();
        wait_req("t5b");
        check("t5 restart addr", mem_addr, 32'h0);
        repeat (4) step();

`ifdef FETCH_TIMEOUT_EN
        // 6: timeout without ack, then ack exactly on the limit cycle
        lat = 0; instr_ready = 1'b1;
        do_reset();
        wait_req("t6");
        repeat (3) step();
        check("t6 no fault yet", fetch_fault, 0);
        step();
        check("t6 timeout fault", fetch_fault, 1);
        lat = 4;
        do_reset();
        wait_req("t6b");
        repeat (3) step();
        check("t6b ack on limit", mem_ack, 1);
        step();
        check("t6b no fault", fetch_fault, 0);
        check("t6b valid", instr_valid, 1);
        repeat (2) step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the program counter and issues word reads to instruction memory over a req/ack interface.
- Presents each fetched word with its PC to the decoder under a valid/ready handshake.
- Accepts PC redirects (JAL/JALR/taken branch) from the execute stage and squashes in-flight or held instructions on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
TIMEOUT_CYCLES, 255, max cycles a memory request may stay unacknowledged (only with FETCH_TIMEOUT_EN); range 1..1023

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  fetch enable; low stops new requests
redirect  input  1  load new PC this cycle
redirect_pc  input  32  redirect target
mem_req  output  1  instruction read request
mem_addr  output  32  word address (byte address, [1:0]=0)
mem_ack  input  1  read data valid, completes request
mem_rdata  input  32  instruction word
instr  output  32  fetched instruction, to decoder
instr_valid  output  1  instr/pc_out valid; drives decoder ce
instr_ready  input  1  decoder accepts instr this cycle
pc_out  output  32  PC of instr
fetch_fault  output  1  sticky fault flag

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (rst_n), clock clk.
- Reset values: pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=RESET_PC, instr=0, instr_valid=0, pc_out=0, fetch_fault=0, kill=0.
- IDLE: mem_req=0. If en=1, go to REQ next cycle. The first mem_req rises one cycle after reset release with en=1.
- REQ:
  - mem_req=1, mem_addr=pc.
  - mem_addr is held stable while mem_req=1 (no request abort).
  - On mem_ack with kill=0: instr<=mem_rdata, pc_out<=pc, instr_valid<=1, go to HOLD.
  - Zero-wait memory (ack in the first req cycle) gives instr_valid on the next cycle.
- HOLD:
  - mem_req=0; instr_valid=1; instr and pc_out are stable until handshake.
  - On instr_valid & instr_ready: pc<=pc+4 (mod 2^32, wrap 0xFFFF_FFFC->0), instr_valid<=0, go to REQ if en=1, else IDLE.
- Redirect (any state except FAULT):
  - pc<=redirect_pc.
  - If redirect_pc[1:0]!=0: go to FAULT.
  - In IDLE: stay IDLE; the new pc is used on the next request.
  - In REQ without same-cycle ack: set kill=1. The request completes at the old address; its data is discarded on ack, kill clears, and state stays REQ with the new pc.
  - In REQ with same-cycle ack: data discarded, next cycle REQ at the new pc; kill stays 0.
  - In HOLD: instr_valid<=0, go to REQ (IDLE if en=0).
  - Redirect and handshake in the same cycle: the handshake completes (instruction consumed), and redirect_pc wins over pc+4.
- en deassert: no effect in REQ (the request completes) or HOLD (the instruction stays offered). Applies at the next REQ decision.
- FAULT:
  - fetch_fault=1, mem_req=0, instr_valid=0.
  - Redirect and en are ignored.
  - Exit only via rst_n.
- Reset mid-operation: all state returns to reset values immediately; an outstanding memory ack after reset is ignored (state IDLE).
- Throughput: one instruction per 2 cycles with zero-wait memory, no prefetch.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A 10-bit wait counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES with no ack: next state FAULT, fetch_fault=1.
  - An ack arriving on the same cycle as the limit wins (no fault).
- Not defined:
  - No counter is built; REQ waits indefinitely.
  - fetch_fault is set only by a misaligned redirect.

Test Plan:
1. Reset release, en=1, mem_ack same cycle as mem_req, instr_ready=1 -> mem_addr sequence 0x0,0x4,0x8; pc_out matches; instr_valid pulses every 2nd cycle.
2. 3-cycle ack latency, instr_ready low 4 cycles in HOLD -> instr/pc_out stable; mem_req=0 while held; next mem_addr=pc+4 only after handshake.
3. Redirect to 0x100 in REQ cycle 1 of a 3-cycle access -> old data never presented (instr_valid stays 0); next request at mem_addr=0x100.
4. Redirect to 0x200 in the same cycle as a HOLD handshake -> instruction consumed once; next mem_addr=0x200, not pc+4.
5. Redirect to 0x102 -> fetch_fault=1 next cycle, mem_req=0; later redirect to 0x300 ignored; rst_n low clears fault and restarts at RESET_PC.
6. FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never asserted -> fetch_fault=1 after 4 REQ cycles. Same with ack on the 4th cycle -> no fault, instr_valid next cycle.
